// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a stage's control and data fields.
interface pipe_stage_skid_if #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 76
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  // Producer side drives the payload, consumer side answers with ready.
  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating stall counter.
// Control fields are cleared whenever their entry is invalid; data fields
// are never reset.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 76,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_stage_skid_if.slave      up,
  pipe_stage_skid_if.master     dn,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam bit               HAS_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic              main_valid, main_valid_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic              skid_valid, skid_valid_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              ready_c;
  logic              acc;
  logic              rel;

  // Upstream ready: straight from the skid flop, or combinational without skid.
  always_comb begin
    ready_c = 1'b0;
    if (HAS_SKID) begin
      ready_c = ~skid_valid;
    end else begin
      ready_c = ~main_valid | dn.ready;
    end
  end

  assign acc      = up.valid & ready_c;
  assign rel      = main_valid & dn.ready;
  assign up.ready = ready_c;
  assign dn.valid = main_valid;
  assign dn.ctrl  = main_ctrl;
  assign dn.data  = main_data;

  // Entry next-state: fill, drain, promote skid to main, or capture into skid.
  always_comb begin
    main_valid_n = main_valid;
    main_ctrl_n  = main_ctrl;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_ctrl_n  = skid_ctrl;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_ctrl_n  = '0;
      skid_valid_n = 1'b0;
      skid_ctrl_n  = '0;
    end else if (!main_valid) begin
      if (acc) begin
        main_valid_n = 1'b1;
        main_ctrl_n  = up.ctrl;
        main_data_n  = up.data;
      end
    end else if (rel) begin
      if (skid_valid) begin
        main_ctrl_n  = skid_ctrl;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
        skid_ctrl_n  = '0;
      end else if (acc) begin
        main_ctrl_n  = up.ctrl;
        main_data_n  = up.data;
      end else begin
        main_valid_n = 1'b0;
        main_ctrl_n  = '0;
      end
    end else if (acc && HAS_SKID) begin
      skid_valid_n = 1'b1;
      skid_ctrl_n  = up.ctrl;
      skid_data_n  = up.data;
    end
  end

  // Stall counter next value: count held-but-not-taken cycles, saturating.
  always_comb begin
    cnt_n = stall_cnt;
    if (main_valid && !dn.ready && (stall_cnt != CNT_MAX)) begin
      cnt_n = stall_cnt + CNT_W'(1);
    end
  end

  // Control state: valid bits, control fields and counter, async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      stall_cnt  <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_ctrl  <= main_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_ctrl  <= skid_ctrl_n;
      stall_cnt  <= cnt_n;
    end
  end

  // Data fields carry no reset so they stay plain enable flops.
  always_ff @(posedge clk) begin
    main_data <= main_data_n;
    skid_data <= skid_data_n;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: skid, no-skid and small-counter instances.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush1, flush0, flush4;
  logic [15:0] cnt1, cnt0;
  logic [3:0]  cnt4;
  int          errors = 0;
  int          checks = 0;
  int          rx0    = 0;
  logic [79:0] q1[$];
  logic [79:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) up1();
  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) dn1();
  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) up0();
  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) dn0();
  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) up4();
  pipe_stage_skid_if #(.CTRL_W(4), .DATA_W(76)) dn4();

  pipe_stage_skid #(.CTRL_W(4), .DATA_W(76), .SKID(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .up(up1), .dn(dn1), .stall_cnt(cnt1));
  pipe_stage_skid #(.CTRL_W(4), .DATA_W(76), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .up(up0), .dn(dn0), .stall_cnt(cnt0));
  pipe_stage_skid #(.CTRL_W(4), .DATA_W(76), .SKID(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush4), .up(up4), .dn(dn4), .stall_cnt(cnt4));

  function automatic logic [79:0] mk(input int i);
    logic [3:0] c;
    c = 4'(i) | 4'h8;
    return {c, 12'hA5C, 64'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input bit v, input int i);
    logic [79:0] p;
    p = mk(i);
    up1.valid = v; up1.ctrl = p[79:76]; up1.data = p[75:0];
  endtask

  task automatic drive0(input bit v, input int i);
    logic [79:0] p;
    p = mk(i);
    up0.valid = v; up0.ctrl = p[79:76]; up0.data = p[75:0];
  endtask

  task automatic drive4(input bit v, input int i);
    logic [79:0] p;
    p = mk(i);
    up4.valid = v; up4.ctrl = p[79:76]; up4.data = p[75:0];
  endtask

  // Scoreboard for the skid instance: push on accept, pop and compare on release.
  always @(negedge clk) begin
    logic [79:0] exp;
    if (!reset) begin
      if (dn1.valid && dn1.ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL sb1_unexpected got=%h want=none", {dn1.ctrl, dn1.data});
        end else begin
          exp = q1.pop_front();
          if ({dn1.ctrl, dn1.data} !== exp) begin
            errors++; $display("FAIL sb1_order got=%h want=%h", {dn1.ctrl, dn1.data}, exp);
          end
        end
      end
      if (!dn1.valid) begin
        checks++;
        if (dn1.ctrl !== 4'h0) begin
          errors++; $display("FAIL sb1_ctrl_idle got=%h want=0", dn1.ctrl);
        end
      end
      if (flush1) q1.delete();
      else if (up1.valid && up1.ready) q1.push_back({up1.ctrl, up1.data});
    end
  end

  // Scoreboard for the no-skid instance.
  always @(negedge clk) begin
    logic [79:0] exp;
    if (!reset) begin
      if (dn0.valid && dn0.ready) begin
        checks++;
        rx0++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL sb0_unexpected got=%h want=none", {dn0.ctrl, dn0.data});
        end else begin
          exp = q0.pop_front();
          if ({dn0.ctrl, dn0.data} !== exp) begin
            errors++; $display("FAIL sb0_order got=%h want=%h", {dn0.ctrl, dn0.data}, exp);
          end
        end
      end
      if (flush0) q0.delete();
      else if (up0.valid && up0.ready) q0.push_back({up0.ctrl, up0.data});
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0; flush4 = 1'b0;
    drive1(0, 0); drive0(0, 0); drive4(0, 0);
    dn1.ready = 1'b0; dn0.ready = 1'b0; dn4.ready = 1'b0;
    #3;
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", dn1.valid); end
    checks++; if (dn1.ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", dn1.ctrl); end
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got=%b want=1", up1.ready); end
    checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b want=1", up0.ready); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt1); end
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_cnt4 got=%0d want=0", cnt4); end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid got=%b want=0", dn1.valid); end
  endtask

  task automatic test_streaming();
    logic [79:0] p;
    dn1.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive1(1, i);
      checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b want=1", i, up1.ready); end
      if (i > 0) begin
        p = mk(i - 1);
        checks++;
        if (dn1.valid !== 1'b1 || dn1.data !== p[75:0]) begin
          errors++; $display("FAIL stream_out[%0d] got=%b/%h want=1/%h", i, dn1.valid, dn1.data, p[75:0]);
        end
      end
    end
    tick();
    drive1(0, 0);
    p = mk(7);
    checks++; if (dn1.data !== p[75:0]) begin errors++; $display("FAIL stream_last got=%h want=%h", dn1.data, p[75:0]); end
    tick(); tick();
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL stream_drain got=%0d want=0", q1.size()); end
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b want=0", dn1.valid); end
  endtask

  task automatic test_backpressure();
    logic [79:0] pa, pb, pc;
    pa = mk(100); pb = mk(101); pc = mk(102);
    tick(); dn1.ready = 1'b0; drive1(1, 100);
    tick(); drive1(1, 101);
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== pa[75:0]) begin errors++; $display("FAIL bp_hold_a got=%h want=%h", dn1.data, pa[75:0]); end
    tick(); drive1(1, 102);
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b want=0", up1.ready); end
    checks++; if (dn1.data !== pa[75:0]) begin errors++; $display("FAIL bp_stable1 got=%h want=%h", dn1.data, pa[75:0]); end
    tick();
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low2 got=%b want=0", up1.ready); end
    checks++; if (dn1.ctrl !== pa[79:76]) begin errors++; $display("FAIL bp_stable2 got=%h want=%h", dn1.ctrl, pa[79:76]); end
    tick();
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt got=%0d want=3", cnt1); end
    dn1.ready = 1'b1;
    tick();
    checks++; if (dn1.data !== pb[75:0] || up1.ready !== 1'b1) begin errors++; $display("FAIL bp_b got=%h/%b want=%h/1", dn1.data, up1.ready, pb[75:0]); end
    tick(); drive1(0, 0);
    checks++; if (dn1.data !== pc[75:0]) begin errors++; $display("FAIL bp_c got=%h want=%h", dn1.data, pc[75:0]); end
    tick(); tick();
    checks++; if (q1.size() != 0 || dn1.valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0d/%b want=0/0", q1.size(), dn1.valid); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL bp_cnt_final got=%0d want=3", cnt1); end
  endtask

  task automatic test_flush();
    tick(); dn1.ready = 1'b0; drive1(1, 200);
    tick(); drive1(1, 201);
    tick(); drive1(1, 202); flush1 = 1'b1;
    checks++; if (up1.ready !== 1'b0 || dn1.valid !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b/%b want=0/1", up1.ready, dn1.valid); end
    tick(); flush1 = 1'b0; drive1(0, 0);
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", dn1.valid); end
    checks++; if (dn1.ctrl !== 4'h0) begin errors++; $display("FAIL flush_ctrl got=%h want=0", dn1.ctrl); end
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b want=1", up1.ready); end
    checks++; if (cnt1 !== 16'd5) begin errors++; $display("FAIL flush_cnt_kept got=%0d want=5", cnt1); end
    dn1.ready = 1'b1; drive1(1, 203); flush1 = 1'b1;
    tick(); flush1 = 1'b0; drive1(0, 0);
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL flush_drop_acc got=%b want=0", dn1.valid); end
    tick(); tick();
    checks++; if (dn1.valid !== 1'b0 || q1.size() != 0) begin errors++; $display("FAIL flush_nothing got=%b/%0d want=0/0", dn1.valid, q1.size()); end
  endtask

  task automatic test_async_reset();
    logic [79:0] pp, pr;
    pp = mk(300); pr = mk(302);
    tick(); dn1.ready = 1'b0; drive1(1, 300);
    tick(); drive1(1, 301);
    tick(); drive1(0, 0);
    checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL areset_full got=%b want=0", up1.ready); end
    #3 reset = 1'b1;
    #1;
    checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b want=0", dn1.valid); end
    checks++; if (dn1.ctrl !== 4'h0) begin errors++; $display("FAIL areset_ctrl got=%h want=0", dn1.ctrl); end
    checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b want=1", up1.ready); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL areset_cnt got=%0d want=0", cnt1); end
    checks++; if (dn1.data !== pp[75:0]) begin errors++; $display("FAIL areset_data_kept got=%h want=%h", dn1.data, pp[75:0]); end
    q1.delete();
    tick(); tick();
    reset = 1'b0;
    dn1.ready = 1'b1; drive1(1, 302);
    tick(); drive1(0, 0);
    checks++; if (dn1.valid !== 1'b1 || dn1.data !== pr[75:0]) begin errors++; $display("FAIL areset_after got=%b/%h want=1/%h", dn1.valid, dn1.data, pr[75:0]); end
    tick(); tick();
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL areset_drain got=%0d want=0", q1.size()); end
  endtask

  task automatic test_skid0_toggle();
    int sent;
    logic want;
    sent = 0;
    rx0 = 0;
    q0.delete();
    for (int cyc = 0; cyc < 200 && sent < 16; cyc++) begin
      tick();
      dn0.ready = (cyc % 2 == 0);
      drive0(1, 400 + sent);
      #1;
      want = !dn0.valid || dn0.ready;
      checks++; if (up0.ready !== want) begin errors++; $display("FAIL skid0_ready[%0d] got=%b want=%b", cyc, up0.ready, want); end
      if (up0.ready === 1'b1) sent++;
    end
    checks++; if (sent != 16) begin errors++; $display("FAIL skid0_timeout got=%0d want=16", sent); end
    tick(); drive0(0, 0); dn0.ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (rx0 != 16) begin errors++; $display("FAIL skid0_count got=%0d want=16", rx0); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL skid0_drain got=%0d want=0", q0.size()); end
  endtask

  task automatic test_saturation();
    logic [79:0] p;
    p = mk(500);
    tick(); dn4.ready = 1'b0; drive4(1, 500);
    tick(); drive4(0, 0);
    checks++; if (dn4.valid !== 1'b1 || cnt4 !== 4'd0) begin errors++; $display("FAIL sat_start got=%b/%0d want=1/0", dn4.valid, cnt4); end
    repeat (10) tick();
    checks++; if (cnt4 !== 4'd10) begin errors++; $display("FAIL sat_mid got=%0d want=10", cnt4); end
    repeat (10) tick();
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cap got=%0d want=15", cnt4); end
    checks++; if (dn4.data !== p[75:0]) begin errors++; $display("FAIL sat_hold got=%h want=%h", dn4.data, p[75:0]); end
    dn4.ready = 1'b1;
    tick();
    checks++; if (dn4.valid !== 1'b0 || cnt4 !== 4'd15) begin errors++; $display("FAIL sat_release got=%b/%0d want=0/15", dn4.valid, cnt4); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_skid0_toggle();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
